bcd_time_counter: RTL and testbench

Parametrised two-digit BCD time counter: the generalised successor to the fixed minutes generator. One instance per clock field (seconds, minutes, hours), chained by carry. Adds configurable modulus and start value (60-count, 24-hour, 12-hour fields), a run/hold key, synchronous preset load, and button-driven time setting. An optional down-count mode is available for countdown-timer use.

---
 rtl/bcd_time_counter.sv | 108 ++++++++++
 tb/tb_bcd_time_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Two-digit BCD time field (seconds/minutes/hours) with preset load, run/hold key and button set.
// Steps one cycle after cnt_en; button set lands 3 edges after the press. Optional down count via BCD_TIME_DOWN_EN.
module bcd_time_counter #(
  parameter int MODULUS = 60,
  parameter int MIN_VAL = 0
) (
`ifdef BCD_TIME_DOWN_EN
  input  logic       dir,
`endif
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       cnt_en,
  input  logic       set_mode,
  input  logic       inc_btn,
  input  logic       load,
  input  logic [3:0] load_hi,
  input  logic [3:0] load_lo,
  output logic [3:0] dig_hi,
  output logic [3:0] dig_lo,
  output logic       carry_out
);

  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;
  localparam logic [3:0] MIN_HI = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_LO = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_HI = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_LO = 4'(MAX_VAL % 10);

  // [0],[1] synchronise the raw button; [2] remembers the previous level for edge detection
  logic [2:0] sync;
  logic       inc_pulse;
  logic       at_max;
  logic       at_min;
  logic       wrap;
  logic [3:0] nxt_hi;
  logic [3:0] nxt_lo;
  logic       ld_digits_ok;
  logic       ld_ge_min;
  logic       ld_le_max;
  logic       ld_ok;

  assign inc_pulse = sync[1] & ~sync[2];
  assign at_max    = (dig_hi == MAX_HI) && (dig_lo == MAX_LO);
  assign at_min    = (dig_hi == MIN_HI) && (dig_lo == MIN_LO);

  // Range check done digit-wise, so the preset never needs converting to binary
  assign ld_digits_ok = (load_hi <= 4'd9) && (load_lo <= 4'd9);
  assign ld_ge_min    = (load_hi > MIN_HI) || ((load_hi == MIN_HI) && (load_lo >= MIN_LO));
  assign ld_le_max    = (load_hi < MAX_HI) || ((load_hi == MAX_HI) && (load_lo <= MAX_LO));
  assign ld_ok        = ld_digits_ok && ld_ge_min && ld_le_max;

  always_comb begin
    wrap   = at_max;
    nxt_hi = dig_hi;
    nxt_lo = dig_lo + 4'd1;
    if (at_max) begin
      nxt_hi = MIN_HI;
      nxt_lo = MIN_LO;
    end else if (dig_lo == 4'd9) begin
      nxt_hi = dig_hi + 4'd1;
      nxt_lo = 4'd0;
    end
`ifdef BCD_TIME_DOWN_EN
    if (dir) begin
      wrap   = at_min;
      nxt_hi = dig_hi;
      nxt_lo = dig_lo - 4'd1;
      if (at_min) begin
        nxt_hi = MAX_HI;
        nxt_lo = MAX_LO;
      end else if (dig_lo == 4'd0) begin
        nxt_hi = dig_hi - 4'd1;
        nxt_lo = 4'd9;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_hi    <= MIN_HI;
      dig_lo    <= MIN_LO;
      carry_out <= 1'b0;
      sync      <= 3'b000;
    end else begin
      sync      <= {sync[1:0], inc_btn};
      carry_out <= 1'b0;
      if (load) begin
        dig_hi <= ld_ok ? load_hi : MIN_HI;
        dig_lo <= ld_ok ? load_lo : MIN_LO;
      end else if (key) begin
        // Manual set never drives carry, so adjusting one field leaves the next untouched
        if (set_mode) begin
          if (inc_pulse) begin
            dig_hi <= nxt_hi;
            dig_lo <= nxt_lo;
          end
        end else if (cnt_en) begin
          dig_hi    <= nxt_hi;
          dig_lo    <= nxt_lo;
          carry_out <= wrap;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: a 60-count pair chained by carry, a 12-hour (1..12) field and a 24-hour field.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, key;
  logic [3:0] ld_hi, ld_lo;
  logic       ce_a, sm_a, ib_a, ld_a, ld_b;
  logic       ce_12, ld_12, ce_24, ld_24, zero;
`ifdef BCD_TIME_DOWN_EN
  logic       dir;
`endif

  logic [3:0] a_hi, a_lo, b_hi, b_lo, h12_hi, h12_lo, h24_hi, h24_lo;
  logic       a_c, b_c, h12_c, h24_c;

  int checks = 0;
  int failures = 0;

  bcd_time_counter #(.MODULUS(60), .MIN_VAL(0)) u_a (
`ifdef BCD_TIME_DOWN_EN
    .dir(dir),
`endif
    .clk(clk), .reset(reset), .key(key), .cnt_en(ce_a), .set_mode(sm_a), .inc_btn(ib_a),
    .load(ld_a), .load_hi(ld_hi), .load_lo(ld_lo),
    .dig_hi(a_hi), .dig_lo(a_lo), .carry_out(a_c));

  bcd_time_counter #(.MODULUS(60), .MIN_VAL(0)) u_b (
`ifdef BCD_TIME_DOWN_EN
    .dir(dir),
`endif
    .clk(clk), .reset(reset), .key(key), .cnt_en(a_c), .set_mode(zero), .inc_btn(zero),
    .load(ld_b), .load_hi(ld_hi), .load_lo(ld_lo),
    .dig_hi(b_hi), .dig_lo(b_lo), .carry_out(b_c));

  bcd_time_counter #(.MODULUS(12), .MIN_VAL(1)) u_12 (
`ifdef BCD_TIME_DOWN_EN
    .dir(dir),
`endif
    .clk(clk), .reset(reset), .key(key), .cnt_en(ce_12), .set_mode(zero), .inc_btn(zero),
    .load(ld_12), .load_hi(ld_hi), .load_lo(ld_lo),
    .dig_hi(h12_hi), .dig_lo(h12_lo), .carry_out(h12_c));

  bcd_time_counter #(.MODULUS(24), .MIN_VAL(0)) u_24 (
`ifdef BCD_TIME_DOWN_EN
    .dir(dir),
`endif
    .clk(clk), .reset(reset), .key(key), .cnt_en(ce_24), .set_mode(zero), .inc_btn(zero),
    .load(ld_24), .load_hi(ld_hi), .load_lo(ld_lo),
    .dig_hi(h24_hi), .dig_lo(h24_lo), .carry_out(h24_c));

  typedef struct {
    logic       ld;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       ce;
    logic       key;
    logic [3:0] ehi;
    logic [3:0] elo;
    logic       ec;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic l, logic [3:0] h, logic [3:0] lo, logic c, logic k,
                              logic [3:0] eh, logic [3:0] el, logic ec);
    vec_t v;
    v.ld = l; v.hi = h; v.lo = lo; v.ce = c; v.key = k;
    v.ehi = eh; v.elo = el; v.ec = ec;
    return v;
  endfunction

  // Compares {tens, units, carry}
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h%h carry=%b, expected %h%h carry=%b",
               name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] eh, el;

    // Table for the 1..12 field, one vector per clock
    tbl[0]  = mk(1'b1, 4'h1, 4'h2, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0); // preset 12
    tbl[1]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b1); // 12 -> 01 with carry
    tbl[2]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h2, 1'b0);
    tbl[3]  = mk(1'b1, 4'h1, 4'h3, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0); // 13 out of range
    tbl[4]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h2, 1'b0);
    tbl[5]  = mk(1'b1, 4'h0, 4'hA, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0); // invalid BCD units
    tbl[6]  = mk(1'b1, 4'h0, 4'h9, 1'b1, 1'b1, 4'h0, 4'h9, 1'b0); // load beats tick
    tbl[7]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0); // units roll 9 -> 0
    tbl[8]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h1, 1'b0);
    tbl[9]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0); // key low holds
    tbl[10] = mk(1'b1, 4'h0, 4'h5, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0); // load ignores key
    tbl[11] = mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0); // below MIN_VAL
    tbl[12] = mk(1'b1, 4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0);
    tbl[13] = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0); // idle hold
    tbl[14] = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0);
    tbl[15] = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b1);
    tbl[16] = mk(1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0);
    tbl[17] = mk(1'b1, 4'hA, 4'h1, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0); // invalid BCD tens
    tbl[18] = mk(1'b1, 4'h1, 4'h2, 1'b1, 1'b1, 4'h1, 4'h2, 1'b0);
    tbl[19] = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0); // load at MAX with tick: no carry

    reset = 1'b1; key = 1'b1; ld_hi = 4'h0; ld_lo = 4'h0;
    ce_a = 1'b0; sm_a = 1'b0; ib_a = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
    ce_12 = 1'b0; ld_12 = 1'b0; ce_24 = 1'b0; ld_24 = 1'b0; zero = 1'b0;
`ifdef BCD_TIME_DOWN_EN
    dir = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    check("reset_a",   {a_hi, a_lo, a_c},       {4'h0, 4'h0, 1'b0});
    check("reset_b",   {b_hi, b_lo, b_c},       {4'h0, 4'h0, 1'b0});
    check("reset_h12", {h12_hi, h12_lo, h12_c}, {4'h0, 4'h1, 1'b0});
    check("reset_h24", {h24_hi, h24_lo, h24_c}, {4'h0, 4'h0, 1'b0});

    // Full 60-count run, carry only in the cycle showing 00 after 59
    ce_a = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      eh = 4'((k % 60) / 10);
      el = 4'((k % 60) % 10);
      check("count60", {a_hi, a_lo, a_c}, {eh, el, (k == 60)});
    end
    ce_a = 1'b0;
    step();
    check("count60_after", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
    check("chain_first",   {b_hi, b_lo, b_c}, {4'h0, 4'h1, 1'b0});

    for (int i = 0; i < 20; i++) begin
      ld_12 = tbl[i].ld; ld_hi = tbl[i].hi; ld_lo = tbl[i].lo;
      ce_12 = tbl[i].ce; key = tbl[i].key;
      step();
      check($sformatf("h12_vec%0d", i), {h12_hi, h12_lo, h12_c}, {tbl[i].ehi, tbl[i].elo, tbl[i].ec});
    end
    ld_12 = 1'b0; ce_12 = 1'b0; key = 1'b1;

    // 24-hour field: key low blocks ticks, release wraps with carry
    ld_24 = 1'b1; ld_hi = 4'h2; ld_lo = 4'h3;
    step();
    ld_24 = 1'b0;
    check("h24_load", {h24_hi, h24_lo, h24_c}, {4'h2, 4'h3, 1'b0});
    key = 1'b0; ce_24 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("h24_hold", {h24_hi, h24_lo, h24_c}, {4'h2, 4'h3, 1'b0});
    end
    key = 1'b1;
    step();
    check("h24_wrap", {h24_hi, h24_lo, h24_c}, {4'h0, 4'h0, 1'b1});
    ce_24 = 1'b0;
    step();
    check("h24_idle", {h24_hi, h24_lo, h24_c}, {4'h0, 4'h0, 1'b0});

    // Button set from 59 while ticks are also present: one step, 3 edges after the press, no carry
    ld_a = 1'b1; ld_hi = 4'h5; ld_lo = 4'h9;
    step();
    ld_a = 1'b0;
    check("set_load", {a_hi, a_lo, a_c}, {4'h5, 4'h9, 1'b0});
    sm_a = 1'b1; ce_a = 1'b1; ib_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k < 3) check("set_wait", {a_hi, a_lo, a_c}, {4'h5, 4'h9, 1'b0});
      else       check("set_step", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
      check("set_no_ripple", {b_hi, b_lo, b_c}, {4'h0, 4'h1, 1'b0});
    end
    ib_a = 1'b0; ce_a = 1'b0;
    repeat (3) step();

    // A short press interrupted by reset must not produce a step afterwards
    ib_a = 1'b1;
    step();
    check("rst_set_pre", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
    ib_a = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_set_discard", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
    end
    sm_a = 1'b0;

    // Chain 59:59 -> 00:00, upper stage one cycle behind
    ld_a = 1'b1; ld_b = 1'b1; ld_hi = 4'h5; ld_lo = 4'h9;
    step();
    ld_a = 1'b0; ld_b = 1'b0;
    check("chain_load", {a_hi, a_lo, b_hi, b_lo}, {4'h5, 4'h9, 4'h5, 4'h9});
    ce_a = 1'b1;
    step();
    ce_a = 1'b0;
    check("chain_lo_wrap", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b1});
    check("chain_hi_wait", {b_hi, b_lo, b_c}, {4'h5, 4'h9, 1'b0});
    step();
    check("chain_lo_idle", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
    check("chain_hi_wrap", {b_hi, b_lo, b_c}, {4'h0, 4'h0, 1'b1});
    step();
    check("chain_hi_idle", {b_hi, b_lo, b_c}, {4'h0, 4'h0, 1'b0});
    ce_a = 1'b1;
    repeat (3) step();
    check("chain_run", {a_hi, a_lo, a_c}, {4'h0, 4'h3, 1'b0});
    reset = 1'b1;
    step();
    reset = 1'b0; ce_a = 1'b0;
    check("chain_rst_a", {a_hi, a_lo, a_c}, {4'h0, 4'h0, 1'b0});
    check("chain_rst_b", {b_hi, b_lo, b_c}, {4'h0, 4'h0, 1'b0});

`ifdef BCD_TIME_DOWN_EN
    dir = 1'b1; ce_a = 1'b1;
    step();
    ce_a = 1'b0;
    check("down_wrap", {a_hi, a_lo, a_c}, {4'h5, 4'h9, 1'b1});
    ld_a = 1'b1; ld_hi = 4'h1; ld_lo = 4'h0;
    step();
    ld_a = 1'b0; ce_a = 1'b1;
    step();
    ce_a = 1'b0;
    check("down_borrow_digit", {a_hi, a_lo, a_c}, {4'h0, 4'h9, 1'b0});
    dir = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
